// File: rtl/wb_accum_unit_pkg.sv
// wb_accum_unit shared types and constants.
// Reset level, FSM states, partial-sum width and int8 clamp limits.
package wb_accum_unit_pkg;

  localparam logic RST_EN = 1'b0;

  localparam int PSUM_W = 18;
  localparam int PIX_W  = 9;
  localparam int PASS_W = 8;

  localparam logic [7:0] Q8_MAX = 8'd127;
  localparam logic [7:0] Q8_MIN = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              v;
    logic              first;
    logic              last;
    logic [PIX_W-1:0]  pix;
    logic [PSUM_W-1:0] in1;
    logic [PSUM_W-1:0] in2;
  } s1_t;

endpackage

// File: rtl/wb_accum_unit_if.sv
// Group-sum stream in, ofmap SRAM write port out.
// master = PE-group/ofmap side, slave = wb_accum_unit.
interface wb_accum_unit_if #(
  parameter int ADDR_W = 12
);
  import wb_accum_unit_pkg::*;

  logic              wb_en;
  logic [PSUM_W-1:0] groupsum_in1;
  logic [PSUM_W-1:0] groupsum_in2;
  logic              ofmap_we;
  logic [ADDR_W-1:0] ofmap_addr;
  logic [15:0]       ofmap_data;

  modport master (
    output wb_en,
    output groupsum_in1,
    output groupsum_in2,
    input  ofmap_we,
    input  ofmap_addr,
    input  ofmap_data
  );

  modport slave (
    input  wb_en,
    input  groupsum_in1,
    input  groupsum_in2,
    output ofmap_we,
    output ofmap_addr,
    output ofmap_data
  );

endinterface

// File: rtl/wb_accum_unit_acc_ram.sv
// Accumulator buffer: 1R1W, synchronous read.
// Read-during-write returns old data; the parent forwards.
module wb_accum_unit_acc_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 64,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/wb_accum_unit.sv
// Accumulates PE-group sums across input-channel passes and
// requantises the final pass into int8 pairs for the ofmap SRAM.
module wb_accum_unit
  import wb_accum_unit_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int ACC_DEPTH = 256,
  parameter int ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        cfg_num_pix,
  input  logic [7:0]        cfg_num_pass,
  input  logic [4:0]        cfg_shift,
  input  logic [ADDR_W-1:0] cfg_base,
  wb_accum_unit_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam int AW  = $clog2(ACC_DEPTH);
  localparam int EXT = ACC_W - PSUM_W;

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] quant(
    input logic [ACC_W-1:0] v,
    input logic [4:0]       sh
  );
    logic [ACC_W-1:0] t;
    t = v >> sh;
    if (v[ACC_W-1])
      quant = Q8_MIN;
    else if (t > ACC_W'(Q8_MAX))
      quant = Q8_MAX;
    else
      quant = t[7:0];
  endfunction

  state_t            r_state;
  logic [PIX_W-1:0]  r_pix;
  logic [PASS_W-1:0] r_pass;
  logic [PIX_W-1:0]  r_num_pix;
  logic [PASS_W-1:0] r_num_pass;
  logic [4:0]        r_shift;
  logic [ADDR_W-1:0] r_base;

  s1_t               r_s1;
  logic              r_fw_v;
  logic [AW-1:0]     r_fw_addr;
  logic [2*ACC_W-1:0] r_fw_data;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;

  logic              w_beat;
  logic              w_pix_last;
  logic              w_pass_last;
  logic              w_fwd;
  logic [2*ACC_W-1:0] w_rdata;
  logic [2*ACC_W-1:0] w_old;
  logic [ACC_W-1:0]  w_ext1;
  logic [ACC_W-1:0]  w_ext2;
  logic [ACC_W-1:0]  w_sum1;
  logic [ACC_W-1:0]  w_sum2;

  assign w_beat      = bus.wb_en && (r_state == ST_ACCUM);
  assign w_pix_last  = r_pix == (r_num_pix - 9'd1);
  assign w_pass_last = r_pass == (r_num_pass - 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_EN) begin
      r_state     <= ST_IDLE;
      r_pix       <= '0;
      r_pass      <= '0;
      r_num_pix   <= '0;
      r_num_pass  <= '0;
      r_shift     <= '0;
      r_base      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.wb_en && (r_state != ST_ACCUM))
        err_overrun <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_pix   <= cfg_num_pix;
            r_num_pass  <= cfg_num_pass;
            r_shift     <= cfg_shift;
            r_base      <= cfg_base;
            r_pix       <= '0;
            r_pass      <= '0;
            busy        <= 1'b1;
            err_overrun <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.wb_en) begin
            if (w_pix_last) begin
              r_pix <= '0;
              if (w_pass_last)
                r_state <= ST_DRAIN;
              else
                r_pass <= r_pass + 8'd1;
            end else begin
              r_pix <= r_pix + 9'd1;
            end
          end
        end
        ST_DRAIN: begin
          // final beat is past S1 once r_s1 empties
          if (!r_s1.v) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  wb_accum_unit_acc_ram #(
    .DEPTH (ACC_DEPTH),
    .W     (2*ACC_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_re    (w_beat && (r_pass != '0)),
    .i_raddr (r_pix[AW-1:0]),
    .i_we    (r_s1.v && !r_s1.last),
    .i_waddr (r_s1.pix[AW-1:0]),
    .i_wdata ({w_sum2, w_sum1}),
    .o_rdata (w_rdata)
  );

  assign w_ext1 = {{EXT{r_s1.in1[PSUM_W-1]}}, r_s1.in1};
  assign w_ext2 = {{EXT{r_s1.in2[PSUM_W-1]}}, r_s1.in2};

  // previous beat's write lands on the same edge as this read
  assign w_fwd = r_fw_v && (r_fw_addr == r_s1.pix[AW-1:0]);
  assign w_old = r_s1.first ? '0
               : (w_fwd ? r_fw_data : w_rdata);

  assign w_sum1 = sat_add(w_old[ACC_W-1:0], w_ext1);
  assign w_sum2 = sat_add(w_old[2*ACC_W-1:ACC_W], w_ext2);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_EN) begin
      r_s1      <= '0;
      r_fw_v    <= 1'b0;
      r_fw_addr <= '0;
      r_fw_data <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_s1.v     <= w_beat;
      r_s1.first <= r_pass == '0;
      r_s1.last  <= w_pass_last;
      r_s1.pix   <= r_pix;
      r_s1.in1   <= bus.groupsum_in1;
      r_s1.in2   <= bus.groupsum_in2;
      r_fw_v     <= r_s1.v && !r_s1.last;
      r_fw_addr  <= r_s1.pix[AW-1:0];
      r_fw_data  <= {w_sum2, w_sum1};
      r_we       <= r_s1.v && r_s1.last;
      r_addr     <= r_base + ADDR_W'(r_s1.pix);
      r_data     <= {quant(w_sum2, r_shift), quant(w_sum1, r_shift)};
    end
  end

  assign bus.ofmap_we   = r_we;
  assign bus.ofmap_addr = r_addr;
  assign bus.ofmap_data = r_data;

endmodule

// File: tb/tb_wb_accum_unit.sv
// Scoreboard bench for wb_accum_unit (ACC_W=20 so that
// saturation is reachable with 18-bit inputs).
module tb_wb_accum_unit;

  localparam int ACC_W  = 20;
  localparam int ADDR_W = 12;
  localparam int SMAX   = 524287;
  localparam int SMIN   = -524288;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [8:0]        cfg_num_pix = '0;
  logic [7:0]        cfg_num_pass = '0;
  logic [4:0]        cfg_shift = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic              busy;
  logic              done;
  logic              err_overrun;

  wb_accum_unit_if #(.ADDR_W(ADDR_W)) bus ();

  wb_accum_unit #(
    .ACC_W     (ACC_W),
    .ACC_DEPTH (256),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_num_pix  (cfg_num_pix),
    .cfg_num_pass (cfg_num_pass),
    .cfg_shift    (cfg_shift),
    .cfg_base     (cfg_base),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_we_cyc = -1;
  logic [27:0] sb_q[$];
  logic [27:0] mon_exp;
  int g1[8][8];
  int g2[8][8];
  int acc1[8];
  int acc2[8];

  function automatic int sat20(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic int q8(input int v, input int sh);
    int t;
    if (v < 0) return 0;
    t = v >>> sh;
    return (t > 127) ? 127 : t;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.ofmap_we === 1'b1) begin
      wr_cnt++;
      last_we_cyc = cyc;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h required none",
                 bus.ofmap_addr, bus.ofmap_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({bus.ofmap_addr, bus.ofmap_data} !== mon_exp) begin
          errors++;
          $display("FAIL ofmap_write got addr=%0d data=%h required addr=%0d data=%h",
                   bus.ofmap_addr, bus.ofmap_data, mon_exp[27:16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic clear_g();
    for (int p = 0; p < 8; p++)
      for (int x = 0; x < 8; x++) begin
        g1[p][x] = 0;
        g2[p][x] = 0;
      end
  endtask

  task automatic do_start(input int npix, input int npass,
                          input int sh, input int base);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_num_pix = 9'(npix);
    cfg_num_pass = 8'(npass);
    cfg_shift = 5'(sh);
    cfg_base = 12'(base);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_num_pix = 9'd1;
    cfg_num_pass = 8'd1;
    cfg_shift = 5'd31;
    cfg_base = 12'hABC;
  endtask

  task automatic drive_tile(input int npix, input int npass,
                            input int sh, input int base,
                            input bit gaps, input int start_at,
                            input int stop_at);
    int n;
    n = 0;
    for (int p = 0; p < npass; p++)
      for (int x = 0; x < npix; x++) begin
        if (n == stop_at) begin
          bus.wb_en = 1'b0;
          return;
        end
        if (gaps && $urandom_range(0, 2) == 0) begin
          bus.wb_en = 1'b0;
          @(posedge clk); #1;
        end
        bus.wb_en = 1'b1;
        bus.groupsum_in1 = 18'(g1[p][x]);
        bus.groupsum_in2 = 18'(g2[p][x]);
        start = (n == start_at);
        if (p == 0) begin
          acc1[x] = g1[p][x];
          acc2[x] = g2[p][x];
        end else begin
          acc1[x] = sat20(acc1[x] + g1[p][x]);
          acc2[x] = sat20(acc2[x] + g2[p][x]);
        end
        if (p == npass - 1)
          sb_q.push_back({12'((base + x) % 4096),
                          8'(q8(acc2[x], sh)), 8'(q8(acc1[x], sh))});
        n++;
        @(posedge clk); #1;
      end
    bus.wb_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int at_cyc);
    seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, err_overrun, bus.ofmap_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0000",
               {busy, done, err_overrun, bus.ofmap_we});
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single_pass();
    bit seen;
    int dc;
    clear_g();
    g1[0][0] = 5; g1[0][1] = -3; g1[0][2] = 200; g1[0][3] = 127;
    do_start(4, 1, 0, 100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_busy got %b required 1", busy);
    end
    drive_tile(4, 1, 0, 100, 1'b0, -1, -1);
    wait_done(seen, dc);
    checks++;
    if (!seen || dc != last_we_cyc + 1) begin
      errors++;
      $display("FAIL t1_done_timing got seen=%0d cyc=%0d required cyc=%0d",
               seen, dc, last_we_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL t1_drain got busy=%b pending=%0d required 0/0",
               busy, sb_q.size());
    end
  endtask

  task automatic test_multi_pass();
    bit seen;
    int dc;
    int w0;
    clear_g();
    for (int p = 0; p < 3; p++)
      for (int x = 0; x < 2; x++) g1[p][x] = 10;
    w0 = wr_cnt;
    do_start(2, 3, 2, 40);
    drive_tile(2, 3, 2, 40, 1'b1, -1, -1);
    wait_done(seen, dc);
    checks++;
    if (!seen || wr_cnt - w0 != 2) begin
      errors++;
      $display("FAIL t2_write_count got seen=%0d writes=%0d required 1/2",
               seen, wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int dc;
    clear_g();
    g2[0][0] = -100; g2[1][0] = 50; g2[2][0] = 60; g2[3][0] = 70;
    do_start(1, 4, 0, 7);
    drive_tile(1, 4, 0, 7, 1'b0, -1, -1);
    wait_done(seen, dc);
    checks++;
    if (!seen || dc != last_we_cyc + 1) begin
      errors++;
      $display("FAIL t3_done_timing got seen=%0d cyc=%0d required cyc=%0d",
               seen, dc, last_we_cyc + 1);
    end
  endtask

  task automatic test_saturation();
    bit seen;
    int dc;
    clear_g();
    for (int p = 0; p < 8; p++)
      for (int x = 0; x < 2; x++) begin
        g1[p][x] = 131071;
        g2[p][x] = -131072;
      end
    do_start(2, 8, 12, 500);
    drive_tile(2, 8, 12, 500, 1'b0, -1, -1);
    wait_done(seen, dc);
    checks++;
    if (!seen || sb_q.size() != 0) begin
      errors++;
      $display("FAIL t4_done got seen=%0d pending=%0d required 1/0",
               seen, sb_q.size());
    end
  endtask

  task automatic test_overrun();
    bit seen;
    int dc;
    int w0;
    w0 = wr_cnt;
    @(posedge clk); #1;
    bus.wb_en = 1'b1;
    bus.groupsum_in1 = 18'd33;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_overrun !== 1'b1 || wr_cnt != w0) begin
      errors++;
      $display("FAIL t5_idle_overrun got err=%b writes=%0d required 1/0",
               err_overrun, wr_cnt - w0);
    end
    clear_g();
    g1[0][0] = 3;  g1[0][1] = 4;
    g1[1][0] = 20; g1[1][1] = -9;
    g2[0][0] = 1;  g2[1][1] = 2;
    do_start(2, 2, 0, 200);
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL t5_start_clears got %b required 0", err_overrun);
    end
    drive_tile(2, 2, 0, 200, 1'b1, 1, -1);
    bus.wb_en = 1'b1;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
    wait_done(seen, dc);
    checks++;
    if (!seen || err_overrun !== 1'b1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL t5_drain_overrun got seen=%0d err=%b pending=%0d required 1/1/0",
               seen, err_overrun, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_tile();
    bit seen;
    int dc;
    int w0;
    clear_g();
    for (int p = 0; p < 3; p++)
      for (int x = 0; x < 4; x++) g1[p][x] = 50 + x;
    do_start(4, 3, 0, 300);
    drive_tile(4, 3, 0, 300, 1'b0, -1, 6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t6_busy_before got %b required 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, err_overrun, bus.ofmap_we} !== 4'b0000) begin
      errors++;
      $display("FAIL t6_async_reset got %b required 0000",
               {busy, done, err_overrun, bus.ofmap_we});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    w0 = wr_cnt;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || wr_cnt != w0) begin
      errors++;
      $display("FAIL t6_aborted got done=%0d writes=%0d required 0/0",
               seen, wr_cnt - w0);
    end
    clear_g();
    g1[0][0] = 40; g1[0][1] = -7; g1[0][2] = 1000;
    g2[0][0] = 9;  g2[0][1] = 255; g2[0][2] = -1;
    do_start(3, 1, 1, 310);
    drive_tile(3, 1, 1, 310, 1'b0, -1, -1);
    wait_done(seen, dc);
    checks++;
    if (!seen || dc != last_we_cyc + 1) begin
      errors++;
      $display("FAIL t6_restart_done got seen=%0d cyc=%0d required cyc=%0d",
               seen, dc, last_we_cyc + 1);
    end
  endtask

  task automatic test_random_wrap();
    bit seen;
    int dc;
    clear_g();
    for (int p = 0; p < 3; p++)
      for (int x = 0; x < 8; x++) begin
        g1[p][x] = int'($urandom_range(0, 262142)) - 131071;
        g2[p][x] = int'($urandom_range(0, 4000)) - 1000;
      end
    do_start(8, 3, 9, 4092);
    drive_tile(8, 3, 9, 4092, 1'b1, -1, -1);
    wait_done(seen, dc);
    checks++;
    if (!seen || sb_q.size() != 0) begin
      errors++;
      $display("FAIL t7_done got seen=%0d pending=%0d required 1/0",
               seen, sb_q.size());
    end
  endtask

  initial begin
    bus.wb_en = 1'b0;
    bus.groupsum_in1 = '0;
    bus.groupsum_in2 = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_back_to_back();
    test_saturation();
    test_overrun();
    test_reset_mid_tile();
    test_random_wrap();
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
